norm_frame_writer: RTL
======================

Name: norm_frame_writer

Overview:
- Producer side of the normalization path: captures one cropped frame of OUT_ROWS*OUT_COLS pixels from the crop-filter AXI-Stream into an on-chip frame buffer.
- Tracks the frame maximum while capturing, then publishes it as norm_denominator.
- Replays the buffered frame on an AXI-Stream master into the normalization reader.
- Turns the crop stream plus an unknown max into a stream whose denominator is known before the first output pixel.

Parameters:
OUT_ROWS, 10, frame rows
OUT_COLS, 10, frame columns
DATA_WIDTH, 8, pixel width in bits

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
ap_start  in  1  start one capture/replay frame
ap_ready  out  1  high in IDLE (can accept ap_start)
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse after last output beat accepted
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input pixel ready
s_axis_tdata  in  DATA_WIDTH  input pixel
m_axis_tvalid  out  1  output pixel valid
m_axis_tready  in  1  output pixel ready
m_axis_tdata  out  DATA_WIDTH  output pixel
m_axis_tlast  out  1  marks pixel N_PIX-1
norm_denominator  out  DATA_WIDTH  frame max, forced to 1 if max is 0
denom_valid  out  1  norm_denominator valid for current frame

Behaviour:
- N_PIX = OUT_ROWS*OUT_COLS. Counters wr_cnt and rd_cnt are $clog2(N_PIX) bits wide.
- Reset values:
  - state IDLE.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, ap_done=0.
  - ap_ready=1, ap_idle=1.
  - norm_denominator=1, denom_valid=0.
  - Counters 0, max_reg 0.
- IDLE:
  - s_axis_tready=0.
  - On ap_start: wr_cnt<=0, max_reg<=0, denom_valid<=0, go to CAPTURE.
- CAPTURE:
  - s_axis_tready=1.
  - Each handshake writes mem[wr_cnt]<=tdata, increments wr_cnt, and sets max_reg<=max(max_reg,tdata).
  - On the handshake with wr_cnt==N_PIX-1:
    - norm_denominator<=max(max_reg,tdata), or 1 if that value is 0.
    - denom_valid<=1.
    - rd_cnt<=0, go to EMIT.
  - The final pixel's value must be included in the max (same-cycle compare).
- EMIT:
  - s_axis_tready=0.
  - RAM read latency is 1 cycle; the output data register is fed by a read-ahead plus 1-entry skid.
  - First m_axis_tvalid appears 2 cycles after entering EMIT.
  - With tready held high, throughput is 1 beat/cycle and there are no bubbles.
  - While tvalid && !tready, m_axis_tdata and m_axis_tlast must be held stable, with no reads lost or duplicated.
  - m_axis_tlast=1 only on beat rd_cnt==N_PIX-1.
  - When the tlast beat is accepted, go to DONE.
- DONE: ap_done=1 for exactly one cycle, then IDLE. denom_valid stays 1 until the next ap_start or reset.
- ap_start outside IDLE is ignored.
- ap_start in the same cycle as reset: reset wins.
- Reset mid-CAPTURE or mid-EMIT discards the frame and returns to reset values. The RAM contents are don't-care.
- Writes stop in every state except CAPTURE, so there is no overflow case. wr_cnt never wraps inside one frame.

Decomposition:
- Shared package norm_pkg:
  - state enum typedef {IDLE, CAPTURE, EMIT, DONE}.
  - Default constants DEF_OUT_ROWS, DEF_OUT_COLS, DEF_DATA_WIDTH.
- One sub-module, frame_buffer_ram:
  - Simple dual-port: 1 write port, 1 registered read port.
  - Depth N_PIX, width DATA_WIDTH, 1-cycle read latency.
  - Inferable as BRAM/LUTRAM.
- Top level holds the FSM, counters, max tracker and output skid.

Test Plan:
- Ramp capture:
  - Stimulus: ap_start, then input pixels 0..99 with s_axis_tvalid=1 and m_axis_tready=1.
  - Response: norm_denominator=99 and denom_valid=1 after beat 99. Output is 0..99 in order with tlast only on 99. ap_done pulses once, one cycle after the last handshake. ap_idle returns to 1.
- Zero frame:
  - Stimulus: 100 pixels of 0.
  - Response: norm_denominator=1, 100 output beats of 0.
- Max on last pixel:
  - Stimulus: 99 pixels of 7, then a final pixel of 255.
  - Response: norm_denominator=255, and beat 99 of the output is 255.
- Backpressure and input gaps:
  - Stimulus: random s_axis_tvalid gaps (~30%), random m_axis_tready low (~50%), random frame data.
  - Response: output equals input exactly, 100 beats, and tdata/tlast are stable whenever tvalid && !tready.
- Control robustness:
  - Stimulus: ap_start pulsed during EMIT.
  - Response: it is ignored, the frame completes normally, and ap_done pulses once.
  - Stimulus: reset asserted after input beat 40.
  - Response: all outputs return to reset values, and a subsequent full frame captures and replays correctly.
- Back-to-back frames:
  - Stimulus: ap_start in the first IDLE cycle after ap_done. Frame A has max 50; frame B has max 200.
  - Response: denom_valid drops at the second start and norm_denominator updates to 200 at the end of frame B's capture.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and default sizing for the normalization frame writer.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int unsigned DEF_OUT_ROWS   = 10;
    localparam int unsigned DEF_OUT_COLS   = 10;
    localparam int unsigned DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/norm_frame_writer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port (1-cycle latency).
module frame_buffer_ram #(
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/norm_frame_writer.sv
// Captures one frame into a buffer while tracking its max, publishes the max as the
// normalization denominator, then replays the frame on an AXI-Stream master.
module norm_frame_writer
    import norm_pkg::*;
#(
    parameter int unsigned OUT_ROWS   = DEF_OUT_ROWS,
    parameter int unsigned OUT_COLS   = DEF_OUT_COLS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] norm_denominator,
    output logic                  denom_valid
);

    localparam int unsigned N_PIX = OUT_ROWS * OUT_COLS;
    localparam int unsigned AW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_PIX - 1);

    state_t                state, state_next;
    logic [AW-1:0]         wr_cnt, rd_cnt;
    logic [DATA_WIDTH-1:0] max_reg, max_new, ram_rdata, skid_data;
    logic                  wr_fire, last_wr, rd_issue, rd_all;
    logic                  ram_vld, ram_last, skid_vld, skid_last;
    logic                  pop, out_free;
    logic [1:0]            occ;

    assign wr_fire  = (state == CAPTURE) && s_axis_tvalid && s_axis_tready;
    assign last_wr  = wr_fire && (wr_cnt == LAST_IDX);
    assign max_new  = (s_axis_tdata > max_reg) ? s_axis_tdata : max_reg;
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign out_free = !m_axis_tvalid || pop;

    frame_buffer_ram #(
        .DEPTH      (N_PIX),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_cnt),
        .wdata (s_axis_tdata),
        .re    (rd_issue),
        .raddr (rd_cnt),
        .rdata (ram_rdata)
    );

    // Read-ahead: issue only if the in-flight read will still find a slot in out/skid
    always_comb begin
        rd_issue = 1'b0;
        occ      = 2'(m_axis_tvalid) + 2'(skid_vld) + 2'(ram_vld);
        if ((state == EMIT) && !rd_all && ((occ - 2'(pop)) <= 2'd1)) begin
            rd_issue = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ap_start) state_next = CAPTURE;
            CAPTURE: if (last_wr) state_next = EMIT;
            EMIT:    if (pop && m_axis_tlast) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs, counters and the max tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            s_axis_tready    <= 1'b0;
            ap_ready         <= 1'b1;
            ap_idle          <= 1'b1;
            ap_done          <= 1'b0;
            norm_denominator <= DATA_WIDTH'(1);
            denom_valid      <= 1'b0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            rd_all           <= 1'b0;
            max_reg          <= '0;
        end else begin
            s_axis_tready <= (state_next == CAPTURE);
            ap_ready      <= (state_next == IDLE);
            ap_idle       <= (state_next == IDLE);
            ap_done       <= (state_next == DONE);
            if ((state == IDLE) && ap_start) begin
                wr_cnt      <= '0;
                max_reg     <= '0;
                denom_valid <= 1'b0;
            end
            if (wr_fire) begin
                wr_cnt  <= wr_cnt + AW'(1);
                max_reg <= max_new;
            end
            if (last_wr) begin
                norm_denominator <= (max_new == '0) ? DATA_WIDTH'(1) : max_new;
                denom_valid      <= 1'b1;
                rd_cnt           <= '0;
                rd_all           <= 1'b0;
            end
            if (rd_issue) begin
                if (rd_cnt == LAST_IDX) begin
                    rd_all <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + AW'(1);
                end
            end
        end
    end

    // Output register fed by the RAM read port, with a one-entry skid for stalls
    always_ff @(posedge clk) begin
        if (reset || (state != EMIT)) begin
            ram_vld       <= 1'b0;
            ram_last      <= 1'b0;
            skid_vld      <= 1'b0;
            skid_last     <= 1'b0;
            skid_data     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            ram_vld  <= rd_issue;
            ram_last <= rd_issue && (rd_cnt == LAST_IDX);
            if (out_free) begin
                if (skid_vld) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_data;
                    m_axis_tlast  <= skid_last;
                    skid_vld      <= ram_vld;
                    skid_data     <= ram_rdata;
                    skid_last     <= ram_last;
                end else if (ram_vld) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= ram_rdata;
                    m_axis_tlast  <= ram_last;
                end else begin
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            end else if (ram_vld) begin
                skid_vld  <= 1'b1;
                skid_data <= ram_rdata;
                skid_last <= ram_last;
            end
        end
    end

endmodule
